// File: rtl/sbqm_people_counter.sv
// sbqm_people_counter: synchronised, debounced entry/exit sensors driving a saturating occupancy counter
module sbqm_people_counter #(
  parameter int n  = 3,
  parameter int DB = 2
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         front_sensor,
  input  logic         back_sensor,
  output logic [n-1:0] pcount,
  output logic         full,
  output logic         empty,
  output logic         err_full,
  output logic         err_empty
);
  localparam int CW = $clog2(DB) + 1;
  localparam logic [CW-1:0] DB_LAST = CW'(DB - 1);
  localparam logic [n-1:0] MAXC = '1;
  logic [1:0]   w_raw;
  logic [1:0]   w_evt;
  logic         w_ent;
  logic         w_ext;
  logic         w_inc;
  logic         w_dec;
  logic [n-1:0] w_next;
  assign w_raw = {back_sensor, front_sensor};
  // Index 0 is the entry sensor, index 1 the exit sensor; both get identical conditioning.
  for (genvar g = 0; g < 2; g++) begin : g_sense
    logic          r_s1;
    logic          r_s2;
    logic          r_db;
    logic          r_prev;
    logic [CW-1:0] r_cnt;
    // Two-flop synchroniser, debounce filter on the synchronised level, and edge-detect delay
    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        r_s1   <= 1'b0;
        r_s2   <= 1'b0;
        r_db   <= 1'b0;
        r_prev <= 1'b0;
        r_cnt  <= '0;
      end else begin
        r_s1   <= w_raw[g];
        r_s2   <= r_s1;
        r_prev <= r_db;
        if (r_s2 != r_db && r_cnt == DB_LAST) begin
          r_db  <= r_s2;
          r_cnt <= '0;
        end else if (r_s2 != r_db) begin
          r_cnt <= r_cnt + CW'(1);
        end else begin
          r_cnt <= '0;
        end
      end
    end
    assign w_evt[g] = r_db & ~r_prev;
  end
  // Simultaneous entry and exit cancel out, so only lone events move the count or raise errors
  always_comb begin
    w_ent  = w_evt[0];
    w_ext  = w_evt[1];
    w_inc  = w_ent & ~w_ext & ~full;
    w_dec  = w_ext & ~w_ent & ~empty;
    w_next = w_inc ? pcount + n'(1) : w_dec ? pcount - n'(1) : pcount;
  end
  // Count, flags from the next value so they track pcount exactly, and single-cycle reject pulses
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pcount    <= '0;
      full      <= 1'b0;
      empty     <= 1'b1;
      err_full  <= 1'b0;
      err_empty <= 1'b0;
    end else begin
      pcount    <= w_next;
      full      <= w_next == MAXC;
      empty     <= w_next == '0;
      err_full  <= w_ent & ~w_ext & full;
      err_empty <= w_ext & ~w_ent & empty;
    end
  end
endmodule
